// File: rtl/ppm16_rx_byte_fifo.sv
// PPM16 receive byte packer plus first-word-fall-through byte FIFO.
// Optional per-entry start-of-packet tag: define PPM_FIFO_SOP_TAG_EN.
module ppm16_rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sym_valid,
    input  logic [3:0]            sym,
    input  logic                  packet_start,
    input  logic                  rd_en,
    input  logic                  clear_overflow,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  rd_sop,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  full,
    output logic                  half_byte,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef PPM_FIFO_SOP_TAG_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {S_WAIT, S_HI, S_LO} state_t;

    state_t                state_q, state_d;
    logic [3:0]            nib_q, nib_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q;
    logic [EW-1:0]         mem_q [DEPTH];

    logic                  wr_req, wr_acc, pop;
    logic [EW-1:0]         wr_entry;

    // Assembler: packet_start always wins and re-aligns the nibble pairing.
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        wr_req  = 1'b0;
        if (packet_start) begin
            if (sym_valid) begin
                nib_d   = sym;
                state_d = S_LO;
            end else begin
                nib_d   = 4'h0;
                state_d = S_HI;
            end
        end else if (sym_valid) begin
            case (state_q)
                S_HI: begin
                    nib_d   = sym;
                    state_d = S_LO;
                end
                S_LO: begin
                    wr_req  = 1'b1;
                    state_d = S_HI;
                end
                default: ;
            endcase
        end
    end

    assign full   = (count_q == FULL_CNT);
    assign pop    = rd_en && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_acc = wr_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

`ifdef PPM_FIFO_SOP_TAG_EN
    logic sop_pend_q;

    // Tag stays pending until a byte is actually stored, so a dropped first byte hands it on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           sop_pend_q <= 1'b0;
        else if (packet_start) sop_pend_q <= 1'b1;
        else if (wr_acc)       sop_pend_q <= 1'b0;
    end

    assign wr_entry = {sop_pend_q, nib_q, sym};
    assign rd_sop   = mem_q[rd_ptr_q][8];
`else
    assign wr_entry = {nib_q, sym};
    assign rd_sop   = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_WAIT;
            nib_q    <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            count_q <= count_d;
            if (wr_acc) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_req && !wr_acc) ovf_q <= 1'b1;
            else if (clear_overflow) ovf_q <= 1'b0;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q][7:0];
    assign rd_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign half_byte  = (state_q == S_LO);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ppm16_rx_byte_fifo.sv
// Randomized and directed bench for ppm16_rx_byte_fifo against a queue-based byte model.
module tb_ppm16_rx_byte_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          sym_valid, packet_start, rd_en, clear_overflow;
    logic [3:0]    sym;
    logic [7:0]    rd_data;
    logic          rd_valid, rd_sop, full, half_byte, overflow;
    logic [DL:0]   fifo_count;

    int checks = 0;
    int errors = 0;

    // Model: stored entries as {sop, byte}; nibble pairing tracked as "have a high nibble".
    logic [8:0] mq[$];
    bit         m_act, m_have, m_sop, m_ovf;
    logic [3:0] m_hi;

    ppm16_rx_byte_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .resetn(resetn), .sym_valid(sym_valid), .sym(sym),
        .packet_start(packet_start), .rd_en(rd_en), .clear_overflow(clear_overflow),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_sop(rd_sop), .fifo_count(fifo_count),
        .full(full), .half_byte(half_byte), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_status();
        return {mq.size() != 0, 5'(mq.size()), mq.size() == DEPTH, m_have, m_ovf};
    endfunction

    function automatic logic exp_sop();
`ifdef PPM_FIFO_SOP_TAG_EN
        return (mq.size() != 0) ? mq[0][8] : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_act = 0; m_have = 0; m_sop = 0; m_ovf = 0; m_hi = 4'h0;
    endfunction

    // Drive one clock of stimulus and advance the model at the same edge.
    task automatic tick(input logic sv, input logic [3:0] s, input logic ps,
                        input logic re, input logic co);
        bit         wr, popped;
        int         sz;
        logic [7:0] b;
        sym_valid = sv; sym = s; packet_start = ps; rd_en = re; clear_overflow = co;
        @(posedge clk);
        wr = 0; b = 8'h00;
        if (ps) begin
            m_act = 1; m_sop = 1; m_have = sv; m_hi = s;
        end else if (m_act && sv) begin
            if (!m_have) begin
                m_have = 1; m_hi = s;
            end else begin
                wr = 1; b = {m_hi, s}; m_have = 0;
            end
        end
        sz = mq.size();
        popped = re && (sz != 0);
        if (popped) void'(mq.pop_front());
        if (co) m_ovf = 0;
        if (wr) begin
            if (sz < DEPTH || popped) begin
                mq.push_back({m_sop, b}); m_sop = 0;
            end else m_ovf = 1;
        end
        #1;
        sym_valid = 0; packet_start = 0; rd_en = 0; clear_overflow = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #7;
        model_reset();
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sym_valid = 0; sym = 0; packet_start = 0; rd_en = 0; clear_overflow = 0;
        resetn = 1'b0;
        #3;
        model_reset();
        checks++;
        if ({rd_valid, fifo_count, full, half_byte, overflow, rd_data, rd_sop} !== 18'h0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", {rd_valid, fifo_count, full, half_byte, overflow, rd_data, rd_sop});
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_ignore();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 4'hF, 0, 0, 0);
            checks++;
            if (fifo_count !== 5'd0 || half_byte !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore count/half got %0d/%b want 0/0", fifo_count, half_byte);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        tick(0, 0, 1, 0, 0);
        tick(1, 4'hA, 0, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || half_byte !== 1'b1) begin
            errors++;
            $display("FAIL basic after_hi valid/half got %b/%b want 0/1", rd_valid, half_byte);
        end
        tick(1, 4'h5, 0, 0, 0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic first_byte valid/data got %b/%h want 1/a5", rd_valid, rd_data);
        end
        tick(1, 4'h3, 0, 0, 0);
        tick(1, 4'hC, 0, 0, 0);
        checks++;
        if (fifo_count !== 5'd2 || exp_status() !== {rd_valid, fifo_count, full, half_byte, overflow}) begin
            errors++;
            $display("FAIL basic peak_count got %0d want 2", fifo_count);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (rd_data !== 8'h3C || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL basic second_byte data/count got %h/%0d want 3c/1", rd_data, fifo_count);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL basic drained valid/count got %b/%0d want 0/0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_restart_discard();
        do_reset();
        tick(0, 0, 1, 0, 0);
        tick(1, 4'h7, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        checks++;
        if (half_byte !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL restart discard half/count got %b/%0d want 0/0", half_byte, fifo_count);
        end
        tick(1, 4'h1, 0, 0, 0);
        tick(1, 4'h2, 0, 0, 0);
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'h12) begin
            errors++;
            $display("FAIL restart stored count/data got %0d/%h want 1/12", fifo_count, rd_data);
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] b;
        do_reset();
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            b = 8'h80 + 8'(i);
            tick(1, b[7:4], 0, 0, 0);
            tick(1, b[3:0], 0, 0, 0);
        end
        checks++;
        if ({full, fifo_count, overflow, rd_data} !== {1'b1, 5'd16, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL full full/count/ovf/head got %b/%0d/%b/%h want 1/16/1/80", full, fifo_count, overflow, rd_data);
        end
        tick(0, 0, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow got %b want 0", overflow);
        end
        tick(1, 4'hE, 0, 0, 0);
        tick(1, 4'h7, 0, 1, 0);
        checks++;
        if ({full, fifo_count, overflow, rd_data} !== {1'b1, 5'd16, 1'b0, 8'h81}) begin
            errors++;
            $display("FAIL full_pop_write full/count/ovf/head got %b/%0d/%b/%h want 1/16/0/81", full, fifo_count, overflow, rd_data);
        end
        // Drop with a simultaneous clear: set wins.
        tick(1, 4'h1, 0, 0, 0);
        tick(1, 4'h2, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1 || exp_status() !== {rd_valid, fifo_count, full, half_byte, overflow}) begin
            errors++;
            $display("FAIL ovf_set_wins ovf got %b want 1", overflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        logic [7:0] b;
        int cyc = 0;
        do_reset();
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            b = 8'(i);
            for (int h = 0; h < 2; h++) begin
                if (cyc[0] && rd_valid) got.push_back(rd_data);
                tick(1, (h == 0) ? b[7:4] : b[3:0], 0, cyc[0], 0);
                cyc++;
            end
        end
        for (int k = 0; k < 64 && rd_valid; k++) begin
            got.push_back(rd_data);
            tick(0, 0, 0, 1, 0);
        end
        checks++;
        if (got.size() != 40) begin
            errors++;
            $display("FAIL wrap count got %0d want 40", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== 8'(k)) begin
                errors++;
                $display("FAIL wrap byte%0d got %h want %h", k, got[k], 8'(k));
            end
        end
    endtask

    task automatic test_sop_tag();
        logic want [4];
`ifdef PPM_FIFO_SOP_TAG_EN
        want = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        want = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int p = 0; p < 2; p++) begin
            tick(0, 0, 1, 0, 0);
            for (int s = 0; s < 4; s++) tick(1, 4'(p * 4 + s), 0, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_sop !== want[k]) begin
                errors++;
                $display("FAIL sop_tag byte%0d valid/sop got %b/%b want 1/%b", k, rd_valid, rd_sop, want[k]);
            end
            tick(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            checks++;
            if ({rd_valid, fifo_count, full, half_byte, overflow} !== exp_status() ||
                (mq.size() != 0 && (rd_data !== mq[0][7:0] || rd_sop !== exp_sop()))) begin
                errors++;
                $display("FAIL random cyc%0d status/data/sop got %h/%h/%b want %h/%h/%b", c,
                         {rd_valid, fifo_count, full, half_byte, overflow}, rd_data, rd_sop,
                         exp_status(), (mq.size() != 0) ? mq[0][7:0] : 8'h00, exp_sop());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(0, 0, 1, 0, 0);
        tick(1, 4'h4, 0, 0, 0);
        tick(1, 4'h2, 0, 0, 0);
        tick(1, 4'h9, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({rd_valid, fifo_count, full, half_byte, overflow, rd_data, rd_sop} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset outputs got %h want 0", {rd_valid, fifo_count, full, half_byte, overflow, rd_data, rd_sop});
        end
        #2;
        resetn = 1'b1;
        tick(1, 4'h3, 0, 0, 0);
        tick(1, 4'h3, 0, 0, 0);
        checks++;
        if (fifo_count !== 5'd0 || half_byte !== 1'b0) begin
            errors++;
            $display("FAIL async_reset back_to_wait count/half got %0d/%b want 0/0", fifo_count, half_byte);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_restart_discard();
        test_full_overflow();
        test_wrap();
        test_sop_tag();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
